unix_time_load_ctrl: RTL and testbench

Controller that owns the load/run inputs of the design's 64-bit Unix-seconds counter and shares its load path between two requesters. Requester A is the front-panel time-set logic; requester B is the external time-sync source. The block runs round-robin arbitration and a req/ack handshake. It drives the counter's load_n, go and set_counter inputs and freezes counting while a load is in progress.

---
 rtl/unix_time_load_ctrl.sv | 132 +++++++++++++
 tb/tb_unix_time_load_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unix_time_load_ctrl.sv
// Load/run controller for the 64-bit Unix-seconds counter.
// Arbitrates two load requesters round-robin and holds the counter frozen while a value is loaded.
module unix_time_load_ctrl #(
    parameter int N           = 64,
    parameter int HOLD_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_a,
    input  logic [N-1:0] data_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [N-1:0] data_b,
    output logic         ack_b,
    input  logic         pause,
    output logic         counter_load_n,
    output logic         counter_go,
    output logic [N-1:0] counter_set,
    output logic         busy,
    output logic         last_grant
);

    // A zero hold would leave no load pulse at all, so it is raised to one cycle.
    localparam int         HOLD      = (HOLD_CYCLES < 1) ? 1 : ((HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACK,
        WAIT_DROP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     hold_cnt_q, hold_cnt_d;
    logic           load_n_q, load_n_d;
    logic           go_q, go_d;
    logic [N-1:0]   set_q, set_d;
    logic           ack_a_q, ack_a_d;
    logic           ack_b_q, ack_b_d;
    logic           busy_q, busy_d;
    logic           last_q, last_d;
    logic           grant_b;
    logic           req_owner;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        load_n_d   = load_n_q;
        go_d       = go_q;
        set_d      = set_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        last_d     = last_q;
        // last_q names the owner of the load in flight once a grant has been made.
        req_owner  = last_q ? req_b : req_a;
        grant_b    = req_b && (!req_a || !last_q);

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    last_d     = grant_b;
                    set_d      = grant_b ? data_b : data_a;
                    load_n_d   = 1'b0;
                    go_d       = 1'b0;
                    hold_cnt_d = HOLD_LAST;
                    state_d    = LOAD;
                end else begin
                    go_d = !pause;
                end
            end
            LOAD: begin
                if (hold_cnt_q == 4'd0) begin
                    load_n_d = 1'b1;
                    go_d     = !pause;
                    ack_a_d  = !last_q;
                    ack_b_d  = last_q;
                    state_d  = ACK;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            ACK: begin
                go_d    = !pause;
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                go_d = !pause;
                // The owner must release before the other requester can be arbitrated.
                if (!req_owner) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= 4'd0;
            load_n_q   <= 1'b1;
            go_q       <= 1'b0;
            set_q      <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            load_n_q   <= load_n_d;
            go_q       <= go_d;
            set_q      <= set_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
        end
    end

    assign counter_load_n = load_n_q;
    assign counter_go     = go_q;
    assign counter_set    = set_q;
    assign ack_a          = ack_a_q;
    assign ack_b          = ack_b_q;
    assign busy           = busy_q;
    assign last_grant     = last_q;

endmodule

// File: tb/tb_unix_time_load_ctrl.sv
// Bench for unix_time_load_ctrl: directed scenarios plus a randomized run
// against a transaction-timeline reference model.
module tb_unix_time_load_ctrl;
    localparam int N    = 64;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         reset, req_a, req_b, pause;
    logic [N-1:0] data_a, data_b;
    logic         ack_a, ack_b, counter_load_n, counter_go, busy, last_grant;
    logic [N-1:0] counter_set;

    int vectors     = 0;
    int miscompares = 0;

    unix_time_load_ctrl #(.N(N), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .pause(pause),
        .counter_load_n(counter_load_n), .counter_go(counter_go),
        .counter_set(counter_set), .busy(busy), .last_grant(last_grant)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model: a load is a timeline measured in edges since its grant.
    bit           m_active;
    int           m_since;
    bit           m_owner;
    bit           m_last = 1'b1;
    bit           m_go;
    logic [N-1:0] m_set = '0;
    logic [N-1:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_since = 0; m_last = 1'b1; m_go = 1'b0; m_set = '0;
            exp_q.delete();
        end else if (!m_active) begin
            if (req_a || req_b) begin
                if (req_a && req_b) m_owner = !m_last;
                else                m_owner = req_b;
                m_active = 1'b1; m_since = 0; m_last = m_owner; m_go = 1'b0;
                m_set = m_owner ? data_b : data_a;
                exp_q.push_back(m_set);
            end else begin
                m_go = !pause;
            end
        end else begin
            if (m_since >= HOLD + 1 && !(m_owner ? req_b : req_a)) m_active = 1'b0;
            m_since++;
            m_go = (m_since >= HOLD) ? !pause : 1'b0;
        end
    end

    function automatic bit m_load_n();
        return !(m_active && m_since < HOLD);
    endfunction
    function automatic bit m_ack(input bit who);
        return m_active && m_since == HOLD && m_owner == who;
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; pause = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; pause = 1'b0; data_a = '0; data_b = '0;
        step(); step(); step();
        vectors++; if (counter_load_n !== 1'b1) begin miscompares++; $display("FAIL reset_load_n: got %b want 1", counter_load_n); end
        vectors++; if (counter_set !== '0) begin miscompares++; $display("FAIL reset_set: got %0d want 0", counter_set); end
        vectors++; if (last_grant !== 1'b1) begin miscompares++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (counter_go !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin miscompares++; $display("FAIL reset_go_ack: got go=%b ack_a=%b ack_b=%b want 0 0 0", counter_go, ack_a, ack_b); end
        reset = 1'b0;
        step();
        vectors++; if (counter_go !== 1'b1) begin miscompares++; $display("FAIL reset_go_after: got %b want 1", counter_go); end
    endtask

    task automatic test_single_load();
        data_a = 64'd1724570400; req_a = 1'b1;
        step();
        vectors++; if (counter_set !== 64'd1724570400) begin miscompares++; $display("FAIL single_set: got %0d want 1724570400", counter_set); end
        vectors++; if (counter_load_n !== 1'b0 || counter_go !== 1'b0) begin miscompares++; $display("FAIL single_k: got load_n=%b go=%b want 0 0", counter_load_n, counter_go); end
        vectors++; if (busy !== 1'b1 || last_grant !== 1'b0 || ack_a !== 1'b0) begin miscompares++; $display("FAIL single_grant: got busy=%b last=%b ack_a=%b want 1 0 0", busy, last_grant, ack_a); end
        step();
        vectors++; if (counter_load_n !== 1'b0 || ack_a !== 1'b0 || counter_go !== 1'b0) begin miscompares++; $display("FAIL single_k1: got load_n=%b ack_a=%b go=%b want 0 0 0", counter_load_n, ack_a, counter_go); end
        step();
        vectors++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin miscompares++; $display("FAIL single_ack: got ack_a=%b ack_b=%b want 1 0", ack_a, ack_b); end
        vectors++; if (counter_load_n !== 1'b1 || counter_go !== 1'b1) begin miscompares++; $display("FAIL single_k2: got load_n=%b go=%b want 1 1", counter_load_n, counter_go); end
        req_a = 1'b0;
        step();
        vectors++; if (ack_a !== 1'b0 || busy !== 1'b1 || counter_go !== 1'b1) begin miscompares++; $display("FAIL single_k3: got ack_a=%b busy=%b go=%b want 0 1 1", ack_a, busy, counter_go); end
        step();
        vectors++; if (busy !== 1'b0 || counter_set !== 64'd1724570400) begin miscompares++; $display("FAIL single_idle: got busy=%b set=%0d want 0 1724570400", busy, counter_set); end
    endtask

    task automatic test_tie();
        logic [N-1:0] va, vb;
        va = {$urandom, $urandom}; vb = {$urandom, $urandom};
        do_reset();
        data_a = va; data_b = vb; req_a = 1'b1; req_b = 1'b1;
        step();
        vectors++; if (last_grant !== 1'b0 || counter_set !== va) begin miscompares++; $display("FAIL tie_first: got last=%b set=%h want 0 %h", last_grant, counter_set, va); end
        step(); step();
        vectors++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin miscompares++; $display("FAIL tie_ack_a: got ack_a=%b ack_b=%b want 1 0", ack_a, ack_b); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (last_grant !== 1'b0 || ack_b !== 1'b0 || counter_load_n !== 1'b1) begin miscompares++; $display("FAIL tie_hold: got last=%b ack_b=%b load_n=%b want 0 0 1", last_grant, ack_b, counter_load_n); end
        end
        req_a = 1'b0;
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tie_release: got busy=%b want 0", busy); end
        step();
        vectors++; if (last_grant !== 1'b1 || counter_set !== vb) begin miscompares++; $display("FAIL tie_second: got last=%b set=%h want 1 %h", last_grant, counter_set, vb); end
        step(); step();
        vectors++; if (ack_b !== 1'b1 || ack_a !== 1'b0) begin miscompares++; $display("FAIL tie_ack_b: got ack_a=%b ack_b=%b want 0 1", ack_a, ack_b); end
        req_b = 1'b0;
        step(); step();
    endtask

    task automatic test_starvation();
        logic [N-1:0] va, vb;
        va = {$urandom, $urandom}; vb = {$urandom, $urandom};
        data_a = va; data_b = vb; req_a = 1'b1; req_b = 1'b0;
        step();
        req_b = 1'b1;
        step(); step();
        vectors++; if (ack_a !== 1'b1) begin miscompares++; $display("FAIL starve_ack_a: got %b want 1", ack_a); end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (last_grant !== 1'b0 || counter_load_n !== 1'b1 || ack_a !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL starve_hold: got last=%b load_n=%b ack_a=%b busy=%b want 0 1 0 1", last_grant, counter_load_n, ack_a, busy); end
        end
        req_a = 1'b0;
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL starve_release: got busy=%b want 0", busy); end
        req_a = 1'b1;
        step();
        vectors++; if (last_grant !== 1'b1 || counter_set !== vb || counter_load_n !== 1'b0) begin miscompares++; $display("FAIL starve_b_first: got last=%b set=%h load_n=%b want 1 %h 0", last_grant, counter_set, counter_load_n, vb); end
        step(); step();
        vectors++; if (ack_b !== 1'b1 || ack_a !== 1'b0) begin miscompares++; $display("FAIL starve_ack_b: got ack_a=%b ack_b=%b want 0 1", ack_a, ack_b); end
        req_a = 1'b0; req_b = 1'b0;
        step(); step();
    endtask

    task automatic test_early_drop_pause();
        int pulses;
        logic [N-1:0] vb;
        vb = {$urandom, $urandom};
        pulses = 0;
        data_b = vb; req_b = 1'b1; pause = 1'b0;
        step();
        vectors++; if (last_grant !== 1'b1 || counter_set !== vb) begin miscompares++; $display("FAIL drop_grant: got last=%b set=%h want 1 %h", last_grant, counter_set, vb); end
        req_b = 1'b0; pause = 1'b1;
        step();
        vectors++; if (counter_load_n !== 1'b0 || counter_go !== 1'b0) begin miscompares++; $display("FAIL drop_load: got load_n=%b go=%b want 0 0", counter_load_n, counter_go); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (ack_b === 1'b1) pulses++;
            vectors++; if (counter_go !== 1'b0 || counter_load_n !== 1'b1) begin miscompares++; $display("FAIL drop_paused: got go=%b load_n=%b want 0 1", counter_go, counter_load_n); end
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL drop_ack_count: got %0d pulses want 1", pulses); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
        pause = 1'b0;
        step();
        vectors++; if (counter_go !== 1'b1) begin miscompares++; $display("FAIL drop_resume: got go=%b want 1", counter_go); end
    endtask

    task automatic test_midload_reset();
        data_a = {$urandom, $urandom}; req_a = 1'b1;
        step();
        reset = 1'b1;
        step();
        vectors++; if (counter_load_n !== 1'b1 || counter_set !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_state: got load_n=%b set=%h busy=%b want 1 0 0", counter_load_n, counter_set, busy); end
        vectors++; if (ack_a !== 1'b0 || last_grant !== 1'b1) begin miscompares++; $display("FAIL midreset_ack: got ack_a=%b last=%b want 0 1", ack_a, last_grant); end
        reset = 1'b0; req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (ack_a !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_after: got ack_a=%b busy=%b want 0 0", ack_a, busy); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            data_a = {$urandom, $urandom};
            data_b = {$urandom, $urandom};
            step();
            vectors++; if (counter_load_n !== m_load_n()) begin miscompares++; $display("FAIL rnd_load_n @%0d: got %b want %b", i, counter_load_n, m_load_n()); end
            vectors++; if (counter_go !== m_go) begin miscompares++; $display("FAIL rnd_go @%0d: got %b want %b", i, counter_go, m_go); end
            vectors++; if (counter_set !== m_set) begin miscompares++; $display("FAIL rnd_set @%0d: got %h want %h", i, counter_set, m_set); end
            vectors++; if (ack_a !== m_ack(1'b0) || ack_b !== m_ack(1'b1)) begin miscompares++; $display("FAIL rnd_ack @%0d: got %b%b want %b%b", i, ack_a, ack_b, m_ack(1'b0), m_ack(1'b1)); end
            vectors++; if (busy !== m_active || last_grant !== m_last) begin miscompares++; $display("FAIL rnd_busy_last @%0d: got %b%b want %b%b", i, busy, last_grant, m_active, m_last); end
            if (ack_a === 1'b1 || ack_b === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rnd_sb_empty @%0d: ack with no granted load", i);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (counter_set !== exp_v) begin miscompares++; $display("FAIL rnd_sb_value @%0d: got %h want %h", i, counter_set, exp_v); end
                end
            end
        end
        vectors++; if (exp_q.size() > 1) begin miscompares++; $display("FAIL rnd_sb_pending: got %0d outstanding want <=1", exp_q.size()); end
        req_a = 1'b0; req_b = 1'b0; pause = 1'b0;
        step(); step(); step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_tie();
        test_starvation();
        test_early_drop_pause();
        test_midload_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
